// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle signed NxN shift-add multiplier controller.
// The decoder raises start for a MULL_INT/MULL_FLT opcode. The block holds
// the PC through the request cycle and N iteration cycles. It then pulses
// wr_en for one cycle with the formatted product on result.
//
// Ports
//   clk     in   rising-edge system clock
//   reset   in   asynchronous active-high reset
//   start   in   decoder request (current opcode is MULL_*)
//   frac    in   0 = integer product, 1 = Q0.(N-1) fractional product
//   a, b    in   N-bit two's complement multiplicand / multiplier
//   stall   out  combinational PC hold (IDLE with start, or RUN)
//   busy    out  registered, high whenever the FSM is not IDLE
//   wr_en   out  registered one-cycle register-file write strobe
//   result  out  registered product, held between operations
module mul_sequencer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         frac,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         stall,
    output logic         busy,
    output logic         wr_en,
    output logic [N-1:0] result
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned AW = 2 * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic            sign_q, sign_d;
    logic            frac_q, frac_d;
    logic [N-1:0]    result_q, result_d;
    logic            wr_en_q, wr_en_d;
    logic            busy_q, busy_d;

    logic [N-1:0]    a_mag, b_mag, addend;
    logic [N:0]      sum_w;
    logic [AW-1:0]   acc_step, prod_s;
    logic [N-1:0]    fmt_w;

    // Operand magnitudes; the most negative value maps onto itself as unsigned.
    assign a_mag = a[N-1] ? N'(~a + N'(1)) : a;
    assign b_mag = b[N-1] ? N'(~b + N'(1)) : b;

    // One shift-add iteration: add into the upper half, then shift right.
    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        sum_w    = {1'b0, acc_q[AW-1:N]} + {1'b0, addend};
        acc_step = AW'({sum_w, acc_q[N-1:0]} >> 1);
        prod_s   = sign_q ? AW'(~acc_step + AW'(1)) : acc_step;
    end

    // Result formatting. In fractional mode the only overflow is (-1)x(-1),
    // the only positive product with bit 2N-2 set; it saturates to max.
    always_comb begin
        if (!frac_q) begin
            fmt_w = prod_s[N-1:0];
        end else if (!prod_s[AW-1] && prod_s[AW-2]) begin
            fmt_w = {1'b0, {(N-1){1'b1}}};
        end else begin
            fmt_w = prod_s[AW-2:N-1];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            frac_q   <= 1'b0;
            result_q <= '0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            frac_q   <= frac_d;
            result_q <= result_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        frac_d   = frac_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d   = a[N-1] ^ b[N-1];
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    frac_d   = frac;
                    acc_d    = '0;
                    cnt_d    = CW'(N);
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                // Last iteration: load the result on the edge entering DONE.
                if (cnt_q == CW'(1)) begin
                    result_d = fmt_w;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_en_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // stall reacts in the request cycle itself, and drops at once under reset.
    assign stall  = !reset && (((state_q == IDLE) && start) || (state_q == RUN));
    assign busy   = busy_q;
    assign wr_en  = wr_en_q;
    assign result = result_q;

endmodule
